// File: rtl/stoch_pkg.sv
// Shared definitions for the stochastic datapath: FSM encoding for the
// stream-to-binary converter and the window-length mapping.
package stoch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // A programmed length of zero means the full 2^width window, so the
    // result needs one extra bit over the programmed field.
    function automatic logic [32:0] window_cycles(input logic [31:0] win_len,
                                                  input int unsigned width);
        if (win_len == 32'd0) begin
            return 33'd1 << width;
        end
        return {1'b0, win_len};
    endfunction

endpackage

// File: rtl/window_counter.sv
// Loadable down counter tracking the cycles left in the current window;
// `last` flags the final sampling cycle.
module window_counter #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] rem,
    output logic         last
);

    logic [W-1:0] rem_q;
    logic [W-1:0] rem_d;

    always_comb begin
        rem_d = rem_q;
        if (load) begin
            rem_d = load_val;
        end else if (en) begin
            rem_d = rem_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign rem  = rem_q;
    assign last = (rem_q == W'(1));

endmodule

// File: rtl/stream_popcount.sv
// Counts the ones of a 1-bit stochastic stream over a programmable window
// and offers the count on a valid/ready output.
module stream_popcount
    import stoch_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] win_len,
    input  logic             bit_in,
    output logic             busy,
    output logic [WIDTH:0]   count,
    output logic             valid,
    input  logic             ready,
    output logic [1:0]       dbg_state
);

    localparam int unsigned CW = WIDTH + 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   count_q, count_d;
    logic            valid_q, valid_d;

    logic            win_load;
    logic            win_en;
    logic            win_last;
    logic [CW-1:0]   win_rem;
    logic [CW-1:0]   win_load_val;

    assign win_load_val = CW'(window_cycles(32'(win_len), WIDTH));

    window_counter #(.W(CW)) u_window_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (win_load),
        .load_val (win_load_val),
        .en       (win_en),
        .rem      (win_rem),
        .last     (win_last)
    );

    // Handshake: valid rises with a fresh count and holds it unchanged
    // until the edge where valid && ready; only then does valid drop and
    // the FSM return to IDLE. count itself is retained afterwards.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        count_d  = count_q;
        valid_d  = valid_q;
        win_load = 1'b0;
        win_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    win_load = 1'b1;
                    acc_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                win_en = 1'b1;
                acc_d  = acc_q + CW'(bit_in);
                if (win_last) begin
                    count_d = acc_q + CW'(bit_in);
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (valid_q && ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign count     = count_q;
    assign valid     = valid_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_stream_popcount.sv
// Directed bench for stream_popcount: window lengths, handshake stall,
// reset abort and single-cycle windows.
module tb_stream_popcount;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] win_len;
    logic             bit_in;
    logic             busy;
    logic [WIDTH:0]   count;
    logic             valid;
    logic             ready;
    logic [1:0]       dbg_state;

    int tests_run = 0;
    int tests_failed = 0;
    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] exp_count;

    stream_popcount #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .win_len   (win_len),
        .bit_in    (bit_in),
        .busy      (busy),
        .count     (count),
        .valid     (valid),
        .ready     (ready),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    task automatic check_result(input string tag);
        exp_count = exp_q.pop_front();
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_count"}, 32'(count), 32'(exp_count));
        check({tag, "_state"}, 32'(dbg_state), 32'd2);
    endtask

    // Accept a start with the given window; returns after edge E0.
    task automatic do_start(input logic [WIDTH-1:0] len, input logic [WIDTH:0] exp);
        win_len = len;
        start   = 1'b1;
        exp_q.push_back(exp);
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; win_len = '0; bit_in = 1'b0; ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_idle("reset");
        check("reset_count", 32'(count), 32'd0);

        // Window 8, constant ones, consumer always ready.
        ready  = 1'b1;
        bit_in = 1'b1;
        do_start(8'd8, 9'd8);
        check("w8_busy_after_e0", 32'(busy), 32'd1);
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("w8_valid_early", 32'(valid), 32'd0);
        end
        tick();
        check_result("w8");
        tick();
        check_idle("w8_after_hs");
        check("w8_count_kept", 32'(count), 32'd8);

        // Window 16 fed by a period-4 zero pulse train.
        do_start(8'd16, 9'd4);
        for (int i = 0; i < 16; i++) begin
            bit_in = (i % 4 == 3);
            tick();
        end
        check_result("w16_zero_train");
        tick();
        check_idle("w16_after_hs");

        // win_len 0 is the full 256-cycle window.
        bit_in = 1'b1;
        do_start(8'd0, 9'd256);
        for (int i = 0; i < 255; i++) tick();
        check("w256_valid_early", 32'(valid), 32'd0);
        tick();
        check_result("w256");
        tick();
        check_idle("w256_after_hs");

        // Stall in HOLD with start pulsed; then handshake with start high.
        ready = 1'b0;
        do_start(8'd3, 9'd2);
        bit_in = 1'b1; tick();
        bit_in = 1'b0; tick();
        bit_in = 1'b1; tick();
        exp_count = exp_q[0];
        check_result("hold");
        exp_q.push_front(exp_count);
        for (int i = 0; i < 5; i++) begin
            start   = (i == 2);
            win_len = 8'd5;
            tick();
            check("hold_valid", 32'(valid), 32'd1);
            check("hold_count", 32'(count), 32'd2);
            check("hold_state", 32'(dbg_state), 32'd2);
        end
        void'(exp_q.pop_front());
        start = 1'b1;
        ready = 1'b1;
        tick();
        start = 1'b0;
        check_idle("hold_after_hs");
        check("hold_count_kept", 32'(count), 32'd2);
        tick();
        check_idle("hs_start_ignored");

        // Reset at the third RUN edge aborts the window.
        bit_in = 1'b1;
        do_start(8'd10, 9'd0);
        void'(exp_q.pop_front());
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("abort");
        check("abort_count", 32'(count), 32'd0);
        do_start(8'd4, 9'd4);
        for (int i = 0; i < 4; i++) tick();
        check_result("after_abort");
        tick();
        check_idle("after_abort_hs");

        // Single-cycle windows.
        do_start(8'd1, 9'd0);
        bit_in = 1'b0;
        tick();
        check_result("w1_zero");
        tick();
        check_idle("w1_zero_hs");
        do_start(8'd1, 9'd1);
        bit_in = 1'b1;
        tick();
        check_result("w1_one");
        tick();
        check_idle("w1_one_hs");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
